// File: rtl/ram_pkg.sv
// Shared constants and types for the RAM stream reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ram_pkg;
    localparam int DEF_RAM_WIDTH  = 8;
    localparam int DEF_RAM_DEPTH  = 512;
    localparam int DEF_ADDR_WIDTH = 9;

    // Two entries cover one word sitting in the FIFO plus one word in the RAM pipe.
    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;
endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry FIFO holding {last, data} words returned by the RAM.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: the head holds while not popped; the caller never pushes into a full FIFO.
module ram_rd_skid
    import ram_pkg::*;
#(
    parameter int W = DEF_RAM_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [W:0]       i_push_dat,
    input  logic             i_pop,
    output logic [W:0]       o_head_dat,
    output logic [OCC_W-1:0] o_occ
);
    logic [W:0]       r_mem [SKID_DEPTH];
    logic             r_wptr;
    logic             r_rptr;
    logic [OCC_W-1:0] r_occ;
    logic             w_push;
    logic             w_pop;

    // Guard both ends so a misbehaving caller cannot corrupt the occupancy count.
    assign w_pop  = i_pop && (r_occ != '0);
    assign w_push = i_push && ((r_occ != OCC_W'(SKID_DEPTH)) || w_pop);

    // Storage, pointers and occupancy; reset clears contents so the head reads zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_dat;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rptr];
    assign o_occ      = r_occ;
endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: fetches a contiguous, wrapping range from the RAM and streams it out.
// Latency: first beat 3 cycles after start is sampled, then one beat per cycle.
// Backpressure: m_ready low stalls the stream; reads stop once FIFO plus RAM pipe hold 2 words.
module ram_stream_reader
    import ram_pkg::*;
#(
    parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
    parameter int RAM_DEPTH  = DEF_RAM_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_length,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_rd_en,
    input  logic [RAM_WIDTH-1:0]  i_rd_data,
    output logic [RAM_WIDTH-1:0]  o_m_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic                  o_m_last
);
    localparam logic [ADDR_WIDTH:0]   L_DEPTH     = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] L_LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   L_ONE       = (ADDR_WIDTH + 1)'(1);

    rd_state_t             r_state;
    rd_state_t             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_issue;
    logic                  w_start_go;
    logic                  w_start_zero;
    logic                  w_pop;
    logic                  w_m_valid;
    logic                  w_last_pop;
    logic                  w_final_issue;
    logic [ADDR_WIDTH:0]   w_len_clamped;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [OCC_W-1:0]      w_occ;
    logic [RAM_WIDTH:0]    w_head;
    logic [2:0]            w_committed;
    logic [2:0]            w_room;

    assign w_start_go    = (r_state == ST_IDLE) && i_start && (i_length != '0);
    assign w_start_zero  = (r_state == ST_IDLE) && i_start && (i_length == '0);
    assign w_len_clamped = (i_length > L_DEPTH) ? L_DEPTH : i_length;
    assign w_addr_nxt    = (r_rd_addr == L_LAST_ADDR) ? '0 : r_rd_addr + ADDR_WIDTH'(1);

    assign w_m_valid  = (w_occ != '0);
    assign w_pop      = w_m_valid && i_m_ready;
    assign w_last_pop = w_pop && w_head[RAM_WIDTH];

    // Words already owned (stored or in the RAM pipe) versus space freed by this cycle's pop.
    assign w_committed   = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_room        = 3'(SKID_DEPTH) + {2'b00, w_pop};
    assign w_final_issue = w_issue && (r_remaining == L_ONE);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and read-issue decision.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_go) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if ((r_remaining != '0) && (w_committed < w_room)) begin
                    w_issue = 1'b1;
                end
                if (w_issue && (r_remaining == L_ONE)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_pop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address/remaining counters, RAM pipe tracking and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_addr       <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_final_issue;
            r_done          <= w_start_zero || ((r_state == ST_DRAIN) && w_last_pop);
            if (w_start_go) begin
                r_rd_addr   <= i_base_addr;
                r_remaining <= w_len_clamped;
                r_busy      <= 1'b1;
            end else if (w_issue) begin
                r_rd_addr   <= w_addr_nxt;
                r_remaining <= r_remaining - L_ONE;
            end
            if ((r_state == ST_DRAIN) && w_last_pop) begin
                r_busy <= 1'b0;
            end
        end
    end

    ram_rd_skid #(
        .W (RAM_WIDTH)
    ) u_skid (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (r_inflight),
        .i_push_dat ({r_inflight_last, i_rd_data}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_occ      (w_occ)
    );

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rd_addr = r_rd_addr;
    assign o_rd_en   = w_issue;
    assign o_m_valid = w_m_valid;
    assign o_m_data  = w_head[RAM_WIDTH-1:0];
    assign o_m_last  = w_m_valid && w_head[RAM_WIDTH];
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader with a behavioural 1-cycle-latency RAM.
// Latency: checks the cycle-exact timing of bursts with m_ready held high.
// Backpressure: directed stall windows plus a random m_ready burst.
module tb_ram_stream_reader;
    localparam int W  = 8;
    localparam int D  = 512;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [W-1:0]  rd_data = '0;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    logic [W-1:0]  mem [D];
    logic [W:0]    exp_q [$];
    logic [W:0]    mon_e;
    int            n_vec = 0;
    int            n_err = 0;
    int            r_n_rden, r_n_wrap, r_n_done, r_n_last;

    always #5 clk = ~clk;

    // Behavioural RAM read port: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    ram_stream_reader #(
        .RAM_WIDTH  (W),
        .RAM_DEPTH  (D),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_length    (length),
        .o_busy      (busy),
        .o_done      (done),
        .o_rd_addr   (rd_addr),
        .o_rd_en     (rd_en),
        .i_rd_data   (rd_data),
        .o_m_data    (m_data),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_m_last    (m_last)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] d, input bit last);
        exp_q.push_back({last, d});
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    int'(busy),    0);
        check({tag, "_done"},    int'(done),    0);
        check({tag, "_rd_en"},   int'(rd_en),   0);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_m_valid"}, int'(m_valid), 0);
        check({tag, "_m_data"},  int'(m_data),  0);
        check({tag, "_m_last"},  int'(m_last),  0);
    endtask

    // Burst with m_ready high: checks every output against the fixed latency table.
    task automatic timed_burst(input int base, input int len);
        start     = 1'b1;
        base_addr = AW'(base);
        length    = (AW + 1)'(len);
        for (int c = 0; c <= len + 4; c++) begin
            @(negedge clk);
            check("t_rd_en",   int'(rd_en),   int'(c >= 1 && c <= len));
            if (c >= 1 && c <= len) check("t_rd_addr", int'(rd_addr), (base + c - 1) % D);
            check("t_m_valid", int'(m_valid), int'(c >= 3 && c <= len + 2));
            check("t_m_last",  int'(m_last),  int'(c == len + 2));
            check("t_done",    int'(done),    int'(c == len + 3));
            check("t_busy",    int'(busy),    int'(c >= 1 && c <= len + 2));
            next_cycle();
            start = 1'b0;
        end
    endtask

    // Runs until done (bounded), counting reads, address wraps, done pulses and last beats.
    task automatic run_to_done(input int budget, input bit rnd,
                               output int n_rden, output int n_wrap,
                               output int n_done, output int n_last);
        int tail;
        tail   = -1;
        n_rden = 0;
        n_wrap = 0;
        n_done = 0;
        n_last = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (rd_en) begin
                n_rden++;
                if (rd_addr == '0) n_wrap++;
            end
            if (done) begin
                n_done++;
                if (tail < 0) tail = 4;
            end
            if (m_valid && m_ready && m_last) n_last++;
            next_cycle();
            start = 1'b0;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            if (tail == 0) break;
            if (tail > 0) tail--;
        end
        check("done_within_budget", int'(tail >= 0), 1);
        m_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b1;
        for (int i = 0; i < D; i++) mem[i] = 8'(i * 37 + 11);
        mem[100] = 8'd6;  mem[101] = 8'd7;  mem[102] = 8'd8;  mem[103] = 8'd9;
        mem[510] = 8'd1;  mem[511] = 8'd2;  mem[0]   = 8'd3;  mem[1]   = 8'd4;

        // Scoreboard monitor: every handshake pops one expected {last, data}.
        fork
            forever begin
                @(negedge clk);
                if (!rst && m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_beat: got data %0d, required no beat", m_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("beat_data", int'(m_data), int'(mon_e[W-1:0]));
                        check("beat_last", int'(m_last), int'(mon_e[W]));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Plain burst.
        push_exp(8'd6, 0); push_exp(8'd7, 0); push_exp(8'd8, 0); push_exp(8'd9, 1);
        timed_burst(100, 4);
        check("plain_q_empty", exp_q.size(), 0);

        // Backpressure: m_ready low for cycles 3..8.
        push_exp(8'd6, 0); push_exp(8'd7, 0); push_exp(8'd8, 0); push_exp(8'd9, 1);
        start = 1'b1; base_addr = 9'd100; length = 10'd4;
        for (int c = 0; c <= 8; c++) begin
            m_ready = (c < 3);
            @(negedge clk);
            if (c == 1 || c == 2) check("bp_rden_issue", int'(rd_en), 1);
            if (c >= 3) begin
                check("bp_rden_stall", int'(rd_en),   0);
                check("bp_valid",      int'(m_valid), 1);
                check("bp_hold_data",  int'(m_data),  6);
                check("bp_hold_last",  int'(m_last),  0);
            end
            next_cycle();
            start = 1'b0;
        end
        m_ready = 1'b1;
        run_to_done(40, 0, r_n_rden, r_n_wrap, r_n_done, r_n_last);
        check("bp_rden_after", r_n_rden, 2);
        check("bp_done_cnt",   r_n_done, 1);
        check("bp_last_cnt",   r_n_last, 1);
        check("bp_q_empty",    exp_q.size(), 0);

        // Wrap across the top of the RAM.
        push_exp(8'd1, 0); push_exp(8'd2, 0); push_exp(8'd3, 0); push_exp(8'd4, 1);
        timed_burst(510, 4);
        check("wrap_q_empty", exp_q.size(), 0);

        // Zero length.
        start = 1'b1; base_addr = 9'd5; length = 10'd0;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            check("zero_done",  int'(done),  int'(c == 1));
            check("zero_busy",  int'(busy),  0);
            check("zero_rd_en", int'(rd_en), 0);
            next_cycle();
            start = 1'b0;
        end

        // Clamp: 600 requested, 512 delivered, one wrap.
        for (int i = 0; i < D; i++) push_exp(mem[(200 + i) % D], i == D - 1);
        start = 1'b1; base_addr = 9'd200; length = 10'd600;
        run_to_done(700, 0, r_n_rden, r_n_wrap, r_n_done, r_n_last);
        check("clamp_rden", r_n_rden, 512);
        check("clamp_wrap", r_n_wrap, 1);
        check("clamp_done", r_n_done, 1);
        check("clamp_last", r_n_last, 1);
        check("clamp_q_empty", exp_q.size(), 0);

        // Start pulsed mid-burst is ignored.
        push_exp(8'd6, 0); push_exp(8'd7, 0); push_exp(8'd8, 0); push_exp(8'd9, 1);
        start = 1'b1; base_addr = 9'd100; length = 10'd4;
        next_cycle();
        start = 1'b0;
        next_cycle();
        start = 1'b1; base_addr = 9'd0; length = 10'd10;
        run_to_done(40, 0, r_n_rden, r_n_wrap, r_n_done, r_n_last);
        check("ign_rden", r_n_rden, 3);
        check("ign_done", r_n_done, 1);
        check("ign_last", r_n_last, 1);
        check("ign_q_empty", exp_q.size(), 0);

        // Reset after two beats (beats at cycles 3 and 4, reset during cycle 5).
        push_exp(8'd6, 0); push_exp(8'd7, 0); push_exp(8'd8, 0); push_exp(8'd9, 1);
        start = 1'b1; base_addr = 9'd100; length = 10'd4;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            start = 1'b0;
        end
        rst = 1'b1;
        check("rst_beats_taken", exp_q.size(), 2);
        exp_q.delete();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        repeat (8) next_cycle();

        // Fresh burst after reset.
        push_exp(8'd6, 0); push_exp(8'd7, 1);
        timed_burst(100, 2);
        check("fresh_q_empty", exp_q.size(), 0);

        // Random m_ready over 64 words.
        for (int i = 0; i < 64; i++) push_exp(mem[(300 + i) % D], i == 63);
        start = 1'b1; base_addr = 9'd300; length = 10'd64;
        run_to_done(1000, 1, r_n_rden, r_n_wrap, r_n_done, r_n_last);
        check("rnd_rden", r_n_rden, 64);
        check("rnd_done", r_n_done, 1);
        check("rnd_last", r_n_last, 1);
        check("rnd_q_empty", exp_q.size(), 0);

        repeat (4) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side initiator for the team's dual-port `ram` block: drives `rd_addr`/`rd_en` and consumes `rd_data`.
- On a `start` command, fetches a contiguous burst of words beginning at a base address. Addresses wrap modulo `RAM_DEPTH`.
- Presents the words as a valid/ready stream.
- Absorbs the RAM's 1-cycle read latency and downstream backpressure with a 2-entry skid FIFO.
- Sits between the RAM and any consumer, e.g. a packetiser or UART transmitter.

Parameters:
- RAM_WIDTH, 8, data word width in bits.
- RAM_DEPTH, 512, number of RAM words.
- ADDR_WIDTH, 9, RAM address width; must satisfy 2^ADDR_WIDTH >= RAM_DEPTH.

Ports:
- clk  in  1  single clock; drives this block and both RAM clocks (`wr_clk` and `rd_clk` tied to `clk`).
- rst  in  1  synchronous, active-high reset.
- start  in  1  command pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first RAM address; sampled with `start`.
- length  in  ADDR_WIDTH+1  words to read; sampled with `start`.
- busy  out  1  high from the cycle after an accepted `start` until `done`.
- done  out  1  one-cycle pulse at burst completion.
- rd_addr  out  ADDR_WIDTH  RAM read address, registered.
- rd_en  out  1  RAM read enable.
- rd_data  in  RAM_WIDTH  RAM read data; valid the cycle after `rd_en`.
- m_data  out  RAM_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with the final beat of the burst.

Behaviour:
- Reset: synchronous, active-high; takes effect at the next `clk` edge, including mid-burst.
  - All outputs go to 0: `busy`, `done`, `rd_en`, `rd_addr`, `m_valid`, `m_data`, `m_last`.
  - FIFO is emptied; in-flight tracking is cleared, so a read issued in the reset cycle is discarded.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: on `start` with `length` == 0, pulse `done` next cycle and stay in IDLE; `busy` stays 0 and no reads are issued.
  - IDLE: on `start` with `length` != 0, latch `base_addr` and len = min(`length`, `RAM_DEPTH`); go to READ.
  - READ -> DRAIN: the cycle the last read is issued.
  - DRAIN -> IDLE: after the handshake on the `m_last` beat; `done` pulses in the following cycle and `busy` falls in that same cycle.
  - `start` is ignored while not in IDLE.
- Issue rule (READ only): assert `rd_en` when remaining > 0 and occ + inflight - pop < 2.
  - occ is FIFO occupancy (0..2).
  - inflight is `rd_en` from the previous cycle.
  - pop = `m_valid` & `m_ready`.
  - A combinational path from `m_ready` to `rd_en` is permitted.
- Address sequencing:
  - First `rd_addr` = base.
  - next = (`rd_addr` == `RAM_DEPTH`-1) ? 0 : `rd_addr`+1; advances only on issue.
  - `rd_addr` holds its value when `rd_en` = 0.
- Data capture: `rd_data` is pushed into the FIFO in the cycle after an issue. The FIFO can never overflow under the issue rule.
- Stream output:
  - `m_valid` = FIFO non-empty; `m_data` = FIFO head.
  - `m_data` and `m_last` are stable while `m_valid` & !`m_ready`.
  - `m_last` is tagged on the word from the final issue.
- Latency with `start` sampled at cycle 0 and `m_ready` = 1:
  - `rd_en` at cycles 1..len.
  - First `m_valid` at cycle 3; one beat per cycle.
  - `m_last` at cycle len+2; `done` at cycle len+3.
- Beat count is exactly len: no loss, duplication or reordering under any `m_ready` pattern.

Decomposition:
- Package `ram_pkg` holds:
  - default `RAM_WIDTH`/`RAM_DEPTH`/`ADDR_WIDTH` constants;
  - the FSM state enum (IDLE/READ/DRAIN);
  - the FIFO depth constant (2).
- Sub-module `ram_rd_skid`: 2-entry FIFO carrying {last, data}, with push, pop and occ outputs.
- The top level holds the FSM, address counter, remaining counter and issue logic.

Test Plan:
- Plain burst: write 6,7,8,9 to addresses 100..103; start base=100, len=4, `m_ready`=1 -> `rd_en` high cycles 1..4; `m_data` 6,7,8,9 on cycles 3..6; `m_last` on 9; `done` at cycle 7.
- Backpressure: same burst with `m_ready`=0 for cycles 3..8 -> `rd_en` stops with occ+inflight=2; `m_data` held at 6; after release, beats 6,7,8,9 delivered exactly once.
- Wrap: addresses 510,511,0,1 preloaded with 1,2,3,4; base=510, len=4 -> `rd_addr` sequence 510,511,0,1; stream 1,2,3,4.
- Zero and clamp: len=0 -> no `rd_en`, `done` at cycle 1, `busy` stays 0. len=600 -> exactly 512 beats; `rd_addr` wraps once; `m_last` on beat 512.
- Ignore and reset: `start` pulsed during a burst is ignored (beat count unchanged). `rst` after 2 beats -> all outputs 0 next cycle, no further beats. A fresh burst afterwards (base=100, len=2) -> 6,7.
- Random `m_ready` (50%) over a len=64 burst -> output sequence equals RAM contents in order; exactly one `m_last` and one `done`.
